// File: rtl/trace_capture.sv
// On-chip trace buffer: captures {timestamp, mon_in} snapshots into a ring buffer
// (STREAM FIFO or WINDOW around a trigger) and replays them word by word over valid/ready.
module trace_capture #(
    parameter int LANE_W    = 32,
    parameter int NUM_LANES = 8,
    parameter int DEPTH     = 16
) (
    input  logic                          in_clk,
    input  logic                          in_reset_n,
    input  logic [NUM_LANES*LANE_W-1:0]   mon_in,
    input  logic                          trig_in,
    input  logic                          cfg_mode,
    input  logic [$clog2(DEPTH)-1:0]      cfg_post,
    input  logic [NUM_LANES-1:0]          lane_mask,
    input  logic                          arm,
    input  logic                          abort,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [LANE_W-1:0]             rd_data,
    output logic                          rd_last,
    output logic [1:0]                    state,
    output logic [$clog2(DEPTH):0]        entry_count,
    output logic [15:0]                   overflow_cnt,
    output logic                          done
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int WW    = $clog2(NUM_LANES + 1);
    localparam int ENT_W = (NUM_LANES + 1) * LANE_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic                   mode_q, mode_d;
    logic [AW-1:0]          post_q, post_d;
    logic [AW-1:0]          post_cnt_q, post_cnt_d;
    logic [NUM_LANES-1:0]   mask_q, mask_d;
    logic [LANE_W-1:0]      ts_q, ts_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [15:0]            ovf_q, ovf_d;
    logic                   rd_valid_q, rd_valid_d;
    logic [LANE_W-1:0]      rd_data_q, rd_data_d;
    logic                   rd_last_q, rd_last_d;
    logic [WW-1:0]          word_q, word_d;

    logic [ENT_W-1:0]       buf_mem [DEPTH];
    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [ENT_W-1:0]       wr_data;
    logic                   full, fire, pop, ovr, rd_allow;
    logic [AW-1:0]          head_ptr;
    logic [CW-1:0]          avail;
    logic [WW-1:0]          nxt;
    logic [ENT_W-1:0]       cur_ent, head_ent;

    // Word w of an entry: 0 is the timestamp, k+1 is lane k.
    function automatic logic [WW-1:0] next_word(input logic [NUM_LANES-1:0] m,
                                                input logic [WW-1:0] w);
        next_word = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--)
            if (m[i] && i >= int'(w)) next_word = WW'(i + 1);
    endfunction

    function automatic logic is_last(input logic [NUM_LANES-1:0] m, input logic [WW-1:0] w);
        is_last = 1'b1;
        for (int i = 0; i < NUM_LANES; i++)
            if (m[i] && i >= int'(w)) is_last = 1'b0;
    endfunction

    assign full     = (count_q == CW'(DEPTH));
    assign fire     = rd_valid_q && rd_ready;
    assign pop      = fire && rd_last_q;
    assign head_ptr = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    assign avail    = count_q - CW'(pop);
    assign rd_allow = (state_q == S_ARMED && !mode_q) || (state_q == S_DONE);
    assign cur_ent  = buf_mem[rd_ptr_q];
    assign head_ent = buf_mem[head_ptr];
    assign nxt      = next_word(mask_q, word_q);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        mode_d     = mode_q;
        post_d     = post_q;
        post_cnt_d = post_cnt_q;
        mask_d     = mask_q;
        ts_d       = ts_q + LANE_W'(1);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        rd_last_d  = rd_last_q;
        word_d     = word_q;
        wr_en      = 1'b0;
        wr_addr    = wr_ptr_q;
        wr_data    = {mon_in, ts_q};
        ovr        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d  = S_ARMED;
                    mode_d   = cfg_mode;
                    post_d   = cfg_post;
                    mask_d   = lane_mask;
                    ovf_d    = '0;
                    ts_d     = LANE_W'(1);
                    rd_ptr_d = '0;
                    // WINDOW history starts with the arm-cycle sample at timestamp 0.
                    wr_en    = cfg_mode;
                    wr_addr  = '0;
                    wr_data  = {mon_in, {LANE_W{1'b0}}};
                    wr_ptr_d = cfg_mode ? AW'(1) : '0;
                    count_d  = cfg_mode ? CW'(1) : '0;
                end
            end
            S_ARMED: begin
                if (!mode_q) begin
                    if (trig_in) begin
                        if (full) begin
                            if (ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
                        end else begin
                            wr_en = 1'b1;
                        end
                    end
                end else begin
                    wr_en = 1'b1;
                    if (trig_in) begin
                        if (post_q == '0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d    = S_POST;
                            post_cnt_d = post_q;
                        end
                    end
                end
            end
            S_POST: begin
                wr_en      = 1'b1;
                post_cnt_d = post_cnt_q - AW'(1);
                if (post_cnt_q == AW'(1)) state_d = S_DONE;
            end
            S_DONE: ;
        endcase

        if (state_q != S_IDLE) begin
            ovr = wr_en && full;
            if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop || ovr) rd_ptr_d = rd_ptr_q + AW'(1);
            if (wr_en && !full && !pop)      count_d = count_q + CW'(1);
            else if (pop && !(wr_en && !full)) count_d = count_q - CW'(1);
            if (state_q == S_DONE && pop && count_q == CW'(1)) state_d = S_IDLE;
        end

        if (!rd_valid_q || fire) begin
            if (rd_valid_q && !rd_last_q) begin
                word_d    = nxt;
                rd_data_d = cur_ent[LANE_W*int'(nxt) +: LANE_W];
                rd_last_d = is_last(mask_q, nxt);
            end else if (rd_allow && avail != '0) begin
                rd_valid_d = 1'b1;
                word_d     = '0;
                rd_data_d  = head_ent[LANE_W-1:0];
                rd_last_d  = is_last(mask_q, '0);
            end else begin
                rd_valid_d = 1'b0;
            end
        end

        if (abort) begin
            state_d    = S_IDLE;
            wr_en      = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            post_cnt_d = '0;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
        end
    end

    always_ff @(posedge in_clk or negedge in_reset_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!in_reset_n) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            post_q     <= '0;
            post_cnt_q <= '0;
            mask_q     <= '0;
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_last_q  <= 1'b0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            post_q     <= post_d;
            post_cnt_q <= post_cnt_d;
            mask_q     <= mask_d;
            ts_q       <= ts_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_last_q  <= rd_last_d;
            word_q     <= word_d;
        end
    end

    // NOTE: the storage array has no reset; validity is tracked by the pointers and count.
    always_ff @(posedge in_clk) begin
        if (wr_en) buf_mem[wr_addr] <= wr_data;
    end

    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_data_q;
    assign rd_last      = rd_last_q;
    assign state        = state_q;
    assign entry_count  = count_q;
    assign overflow_cnt = ovf_q;
    assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture: STREAM, overflow, WINDOW, stall, abort and reset cases.
module tb_trace_capture;

    localparam int LW = 32;
    localparam int NL = 8;
    localparam int DP = 16;

    logic               in_clk = 1'b0;
    logic               in_reset_n = 1'b0;
    logic [NL*LW-1:0]   mon_in = '0;
    logic               trig_in = 1'b0;
    logic               cfg_mode = 1'b0;
    logic [3:0]         cfg_post = '0;
    logic [NL-1:0]      lane_mask = '0;
    logic               arm = 1'b0;
    logic               abort = 1'b0;
    logic               rd_valid;
    logic               rd_ready = 1'b0;
    logic [LW-1:0]      rd_data;
    logic               rd_last;
    logic [1:0]         state;
    logic [4:0]         entry_count;
    logic [15:0]        overflow_cnt;
    logic               done;

    trace_capture #(.LANE_W(LW), .NUM_LANES(NL), .DEPTH(DP)) dut (
        .in_clk(in_clk), .in_reset_n(in_reset_n), .mon_in(mon_in), .trig_in(trig_in),
        .cfg_mode(cfg_mode), .cfg_post(cfg_post), .lane_mask(lane_mask), .arm(arm),
        .abort(abort), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_last(rd_last), .state(state), .entry_count(entry_count),
        .overflow_cnt(overflow_cnt), .done(done)
    );

    always #5 in_clk = ~in_clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [LW:0] got [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] lane(input int t, input int k);
        return 32'h5A00_0000 | (LW'(t) << 8) | LW'(k);
    endfunction

    function automatic logic [NL*LW-1:0] mon_for(input int t);
        logic [NL*LW-1:0] v;
        for (int k = 0; k < NL; k++) v[k*LW +: LW] = lane(t, k);
        return v;
    endfunction

    task automatic tick();
        @(posedge in_clk);
        #1;
        cyc++;
        mon_in = mon_for(cyc);
    endtask

    task automatic do_arm(input logic mode, input logic [3:0] post, input logic [NL-1:0] mask);
        arm = 1'b1; cfg_mode = mode; cfg_post = post; lane_mask = mask;
        cyc = 0;
        mon_in = mon_for(0);
        tick();
        arm = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic wait_words(input string tag, input int n);
        int b = 0;
        while (got.size() < n && b < 200) begin
            tick();
            b++;
        end
        check(tag, 64'(got.size()), 64'(n));
    endtask

    task automatic check_word(input string tag, input int i, input logic [LW-1:0] d, input logic l);
        logic [LW:0] w;
        w = (i < got.size()) ? got[i] : 'x;
        check(tag, 64'(w), 64'({l, d}));
    endtask

    // Handshake recorder and hold-while-stalled checker.
    logic        stall_pend = 1'b0;
    logic [LW-1:0] stall_data;
    logic        stall_last;
    always @(negedge in_clk) begin
        if (!in_reset_n) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                check("hold_valid", 64'(rd_valid), 64'(1));
                check("hold_data", 64'(rd_data), 64'(stall_data));
                check("hold_last", 64'(rd_last), 64'(stall_last));
            end
            if (rd_valid && rd_ready && !abort) got.push_back({rd_last, rd_data});
            stall_pend = rd_valid && !rd_ready && !abort;
            stall_data = rd_data;
            stall_last = rd_last;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge in_clk);
        #1;
        check("rst_state", 64'(state), 64'(0));
        check("rst_valid", 64'(rd_valid), 64'(0));
        check("rst_data", 64'(rd_data), 64'(0));
        check("rst_last", 64'(rd_last), 64'(0));
        check("rst_count", 64'(entry_count), 64'(0));
        check("rst_ovf", 64'(overflow_cnt), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        in_reset_n = 1'b1;
        tick();

        // STREAM, lanes 0 and 2, triggers in cycles 3..5.
        got.delete();
        rd_ready = 1'b1;
        do_arm(1'b0, 4'd0, 8'h05);
        check("s1_state", 64'(state), 64'(1));
        tick(); tick();
        trig_in = 1'b1;
        tick(); tick(); tick();
        trig_in = 1'b0;
        wait_words("s1_words", 9);
        for (int e = 0; e < 3; e++) begin
            check_word("s1_ts", 3*e, LW'(3 + e), 1'b0);
            check_word("s1_l0", 3*e + 1, lane(3 + e, 0), 1'b0);
            check_word("s1_l2", 3*e + 2, lane(3 + e, 2), 1'b1);
        end
        check("s1_count", 64'(entry_count), 64'(0));
        do_abort();
        check("s1_abort_state", 64'(state), 64'(0));

        // STREAM overflow: 20 triggers, no readout, timestamp-only entries.
        got.delete();
        rd_ready = 1'b0;
        do_arm(1'b0, 4'd0, 8'h00);
        trig_in = 1'b1;
        repeat (20) tick();
        trig_in = 1'b0;
        tick();
        check("s2_count", 64'(entry_count), 64'(16));
        check("s2_ovf", 64'(overflow_cnt), 64'(4));
        check("s2_head", 64'(rd_data), 64'(1));
        check("s2_head_last", 64'(rd_last), 64'(1));
        rd_ready = 1'b1;
        wait_words("s2_words", 16);
        for (int i = 0; i < 16; i++) check_word("s2_ts", i, LW'(i + 1), 1'b1);
        check("s2_drained", 64'(entry_count), 64'(0));
        check("s2_ovf_hold", 64'(overflow_cnt), 64'(4));
        do_abort();
        rd_ready = 1'b0;

        // WINDOW, cfg_post=3, trigger in cycle 40, lanes 0 and 7.
        got.delete();
        do_arm(1'b1, 4'd3, 8'h81);
        repeat (39) tick();
        check("w1_armed", 64'(state), 64'(1));
        check("w1_no_valid", 64'(rd_valid), 64'(0));
        check("w1_full", 64'(entry_count), 64'(16));
        trig_in = 1'b1;
        tick();
        trig_in = 1'b0;
        check("w1_post", 64'(state), 64'(2));
        tick(); tick();
        check("w1_not_done", 64'(done), 64'(0));
        tick();
        check("w1_done", 64'(done), 64'(1));
        check("w1_done_state", 64'(state), 64'(3));
        check("w1_count", 64'(entry_count), 64'(16));
        rd_ready = 1'b1;
        wait_words("w1_words", 48);
        for (int e = 0; e < 16; e++) begin
            check_word("w1_ts", 3*e, LW'(28 + e), 1'b0);
            check_word("w1_l0", 3*e + 1, lane(28 + e, 0), 1'b0);
            check_word("w1_l7", 3*e + 2, lane(28 + e, 7), 1'b1);
        end
        check("w1_idle", 64'(state), 64'(0));
        check("w1_empty", 64'(entry_count), 64'(0));
        check("w1_valid_low", 64'(rd_valid), 64'(0));
        rd_ready = 1'b0;

        // WINDOW, cfg_post=0, trigger two cycles after arm.
        got.delete();
        do_arm(1'b1, 4'd0, 8'h00);
        tick();
        trig_in = 1'b1;
        tick();
        trig_in = 1'b0;
        check("w2_done", 64'(done), 64'(1));
        check("w2_count", 64'(entry_count), 64'(3));
        rd_ready = 1'b1;
        wait_words("w2_words", 3);
        for (int i = 0; i < 3; i++) check_word("w2_ts", i, LW'(i), 1'b1);
        check("w2_idle", 64'(state), 64'(0));
        rd_ready = 1'b0;

        // Readout stall: rd_ready toggles every cycle, lanes 1 and 3.
        got.delete();
        do_arm(1'b0, 4'd0, 8'h0A);
        trig_in = 1'b1;
        tick(); tick();
        trig_in = 1'b0;
        begin
            int b = 0;
            while (got.size() < 6 && b < 60) begin
                rd_ready = ~rd_ready;
                tick();
                b++;
            end
        end
        check("st_words", 64'(got.size()), 64'(6));
        for (int e = 0; e < 2; e++) begin
            check_word("st_ts", 3*e, LW'(1 + e), 1'b0);
            check_word("st_l1", 3*e + 1, lane(1 + e, 1), 1'b0);
            check_word("st_l3", 3*e + 2, lane(1 + e, 3), 1'b1);
        end
        check("st_empty", 64'(entry_count), 64'(0));
        rd_ready = 1'b0;
        do_abort();

        // Abort mid-entry together with arm.
        do_arm(1'b0, 4'd0, 8'hFF);
        trig_in = 1'b1;
        tick(); tick();
        trig_in = 1'b0;
        tick();
        check("ab_valid", 64'(rd_valid), 64'(1));
        check("ab_ts", 64'(rd_data), 64'(1));
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("ab_mid_data", 64'(rd_data), 64'(lane(1, 0)));
        check("ab_mid_last", 64'(rd_last), 64'(0));
        abort = 1'b1; arm = 1'b1; cfg_mode = 1'b1;
        tick();
        abort = 1'b0; arm = 1'b0;
        check("ab_state", 64'(state), 64'(0));
        check("ab_valid_low", 64'(rd_valid), 64'(0));
        check("ab_count", 64'(entry_count), 64'(0));
        tick();
        check("ab_arm_ignored", 64'(state), 64'(0));
        check("ab_still_empty", 64'(entry_count), 64'(0));

        // Asynchronous reset in the middle of capture.
        do_arm(1'b0, 4'd0, 8'h01);
        trig_in = 1'b1;
        tick(); tick();
        check("rs_count_pre", 64'(entry_count), 64'(2));
        in_reset_n = 1'b0;
        #1;
        check("rs_state", 64'(state), 64'(0));
        check("rs_valid", 64'(rd_valid), 64'(0));
        check("rs_count", 64'(entry_count), 64'(0));
        check("rs_data", 64'(rd_data), 64'(0));
        tick();
        in_reset_n = 1'b1;
        trig_in = 1'b0;
        tick();
        check("rs_after", 64'(state), 64'(0));
        check("rs_done", 64'(done), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/trace_capture.md
# trace_capture

Synthesizable on-chip trace buffer for the ML accelerator debug path. It captures timestamped snapshots of a multi-lane monitored bus into a ring buffer, either as a FIFO stream on every trigger cycle or as a pre/post-trigger window around the first trigger. It emits the stored entries lane by lane over a valid/ready port, so a host or ILA bridge can rebuild per-lane CSV rows without simulator file I/O. It sits between the accelerator top's monitored-signal/trigger outputs and the debug readout logic.

## Interface
- LANE_W, 32, width of one monitored lane, the readout word and the timestamp
- NUM_LANES, 8, number of lanes in mon_in
- DEPTH, 16, buffer entries; power of two, at least 2
- in_clk  in  1  sole clock, rising edge
- in_reset_n  in  1  asynchronous, active-low reset
- mon_in  in  NUM_LANES*LANE_W  monitored bus; lane k is bits [k*LANE_W +: LANE_W]
- trig_in  in  1  capture trigger, sampled each cycle
- cfg_mode  in  1  0 = STREAM, 1 = WINDOW; sampled on arm
- cfg_post  in  clog2(DEPTH)  WINDOW post-trigger entry count; sampled on arm
- lane_mask  in  NUM_LANES  lanes emitted on readout; sampled on arm
- arm  in  1  single-cycle start pulse
- abort  in  1  single-cycle stop/clear pulse
- rd_valid  out  1  readout word valid
- rd_ready  in  1  readout word accepted
- rd_data  out  LANE_W  readout word
- rd_last  out  1  last word of the current entry
- state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
- entry_count  out  clog2(DEPTH)+1  stored, unpopped entries
- overflow_cnt  out  16  saturating count of dropped STREAM captures
- done  out  1  high while state is DONE

## Operation
- Entry content: free-running timestamp plus the full mon_in vector.
  - The timestamp is a LANE_W-bit cycle counter that wraps.
  - It clears to 0 on the arm cycle and increments every cycle after that.
- Readout order per entry:
  - Timestamp word first.
  - Then each lane with lane_mask=1, in ascending lane index.
  - rd_last is asserted on the final word.
  - If lane_mask is all zero, the entry is the timestamp only, with rd_last=1.
- Entries pop oldest-first on the rd_last handshake.
- arm:
  - Acted on in IDLE only; ignored in every other state.
  - Clears the buffer, entry_count, overflow_cnt and the timestamp.
  - Latches cfg_mode, cfg_post and lane_mask.
  - Moves to ARMED.
- abort:
  - Acted on in any state; moves to IDLE and clears the buffer.
  - Deasserts rd_valid on the next cycle, even mid-entry.
  - Wins over arm in the same cycle.
- STREAM mode (behaves as a FIFO):
  - Stays in ARMED until abort.
  - Each cycle with trig_in=1 writes one entry.
  - If entry_count==DEPTH at the start of that cycle, the write is dropped and overflow_cnt increments, saturating at 0xFFFF. A pop in the same cycle does not rescue the write.
  - Readout is allowed concurrently with capture.
- WINDOW mode:
  - ARMED: writes an entry every cycle. When full, the oldest entry is overwritten and entry_count holds at DEPTH. No readout (rd_valid=0).
  - First trig_in=1 in ARMED: that cycle's sample is written. If cfg_post==0, go to DONE; otherwise go to POST with a counter loaded from cfg_post.
  - POST: writes every cycle, overwriting as in ARMED, and decrements the counter. The write that takes the counter to 0 moves to DONE. trig_in is ignored.
  - DONE: capture is frozen and readout is enabled. When the last entry pops (entry_count reaches 0), go to IDLE.
- No readout in IDLE; rd_valid=0 there.

## Timing
- Reset values:
  - state=IDLE, rd_valid=0, rd_data=0, rd_last=0.
  - entry_count=0, overflow_cnt=0, done=0.
  - Timestamp and pointers 0.
- Capture latency: a sample taken in cycle N is written at the end of N. It can appear on rd_valid no earlier than cycle N+1.
- rd_valid, rd_data and rd_last are registered outputs.
- Once rd_valid is asserted, rd_data and rd_last hold until rd_valid&&rd_ready, except on abort.
- Sustained throughput: one word per cycle while rd_ready=1.
- WINDOW with a trigger in cycle T:
  - Final contents are the entries from cycles T+cfg_post-DEPTH+1 .. T+cfg_post.
  - If fewer samples were taken since arm, the contents start at the arm cycle.
  - done rises in cycle T+cfg_post+1.
- Pointer wrap: modulo DEPTH, with no bubble.

## Test plan
- STREAM, lane_mask=8'b0000_0101, arm at cycle 0, trig_in high in cycles 3..5, rd_ready=1 -> three entries of 3 words each: timestamps 3,4,5, each followed by lane0 then lane2, rd_last on every 3rd word.
- STREAM, DEPTH=16, trig_in held high for 20 cycles with rd_ready=0 -> entry_count=16, overflow_cnt=4, stored timestamps are the first 16 triggered cycles.
- WINDOW, cfg_post=3, trig_in pulse at cycle 40 -> done at cycle 44; readout yields 16 entries with timestamps 28..43, then state returns to IDLE.
- WINDOW, trigger at cycle 2 after arm, cfg_post=0 -> entry_count=3, timestamps 0,1,2.
- Readout stall: rd_ready toggling 1/0 mid-entry -> no word lost or duplicated, and rd_data is stable while stalled.
- Abort in the middle of an entry readout, arm and abort pulsed together, and in_reset_n low mid-capture -> next cycle state=IDLE, rd_valid=0, entry_count=0; the arm is ignored.
